// File: rtl/link_arb_pkg.sv
// Shared types and constants for the two-requester MAC tx link arbiter.
package link_arb_pkg;

    localparam int unsigned NUM_REQ     = 2;
    localparam int unsigned FRAME_CNT_W = 32;
    localparam int unsigned DROP_CNT_W  = 16;

    localparam logic REQ_S0 = 1'b0;
    localparam logic REQ_S1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARB    = 2'd1,
        GRANT0 = 2'd2,
        GRANT1 = 2'd3
    } arb_state_t;

    // Saturating add of 0..2 discarded beats to the drop counter
    function automatic logic [DROP_CNT_W-1:0] drop_sat_add(
        input logic [DROP_CNT_W-1:0] cnt,
        input logic [1:0]            inc
    );
        logic [DROP_CNT_W:0] sum;
        sum = {1'b0, cnt} + (DROP_CNT_W+1)'(inc);
        return sum[DROP_CNT_W] ? '1 : sum[DROP_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/link_arb_rr_pick.sv
// Combinational two-way round-robin winner select: pointer breaks ties only.
module link_arb_rr_pick
    import link_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               ptr,
    output logic               winner_c
);

    always_comb begin
        winner_c = REQ_S0;
        if (req[REQ_S0] && req[REQ_S1]) begin
            winner_c = ptr;
        end else if (req[REQ_S1]) begin
            winner_c = REQ_S1;
        end
    end

endmodule

// File: rtl/link_tx_arbiter.sv
// Frame-level arbiter of two beat streams onto one MAC tx link.
// ARB_STRICT_PRIO_EN: requester 0 always wins; otherwise round-robin.
module link_tx_arbiter
    import link_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned KEEP_WIDTH = 32,
    parameter int unsigned USER_WIDTH = 7
) (
    input  logic                   mac_tx_clk,
    input  logic                   mac_tx_rst_n,

    input  logic                   s0_valid,
    input  logic                   s0_start,
    input  logic                   s0_last,
    output logic                   s0_ready,
    input  logic [DATA_WIDTH-1:0]  s0_data,
    input  logic [KEEP_WIDTH-1:0]  s0_keep,
    input  logic [USER_WIDTH-1:0]  s0_user,

    input  logic                   s1_valid,
    input  logic                   s1_start,
    input  logic                   s1_last,
    output logic                   s1_ready,
    input  logic [DATA_WIDTH-1:0]  s1_data,
    input  logic [KEEP_WIDTH-1:0]  s1_keep,
    input  logic [USER_WIDTH-1:0]  s1_user,

    output logic                   m_valid,
    output logic                   m_start,
    output logic                   m_last,
    input  logic                   m_ready,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic [KEEP_WIDTH-1:0]  m_keep,
    output logic [USER_WIDTH-1:0]  m_user,

    output logic [FRAME_CNT_W-1:0] frame_cnt0,
    output logic [FRAME_CNT_W-1:0] frame_cnt1,
    output logic [DROP_CNT_W-1:0]  drop_cnt
);

    arb_state_t         state_q;
    arb_state_t         state_d;
    logic [NUM_REQ-1:0] req;
    logic               winner;
    logic               frame_done;
    logic               grant_idx;
    logic               orphan0;
    logic               orphan1;

    assign req       = {s1_valid && s1_start, s0_valid && s0_start};
    assign grant_idx = (state_q == GRANT1);

`ifdef ARB_STRICT_PRIO_EN
    assign winner = req[REQ_S0] ? REQ_S0 : REQ_S1;
`else
    logic ptr_q;

    // Preference moves to the other requester whenever a frame completes
    always_ff @(posedge mac_tx_clk or negedge mac_tx_rst_n) begin
        if (!mac_tx_rst_n) begin
            ptr_q <= REQ_S0;
        end else if (frame_done) begin
            ptr_q <= ~grant_idx;
        end
    end

    link_arb_rr_pick u_rr_pick (
        .req      (req),
        .ptr      (ptr_q),
        .winner_c (winner)
    );
`endif

    always_ff @(posedge mac_tx_clk or negedge mac_tx_rst_n) begin
        if (!mac_tx_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and link/ready muxing; the granted stream passes straight through
    always_comb begin
        state_d    = state_q;
        s0_ready   = 1'b0;
        s1_ready   = 1'b0;
        m_valid    = 1'b0;
        m_start    = 1'b0;
        m_last     = 1'b0;
        m_data     = '0;
        m_keep     = '0;
        m_user     = '0;
        frame_done = 1'b0;
        orphan0    = 1'b0;
        orphan1    = 1'b0;

        case (state_q)
            IDLE: begin
                // Mid-frame beats with no owner are swallowed; held off during reset
                orphan0  = s0_valid && !s0_start && mac_tx_rst_n;
                orphan1  = s1_valid && !s1_start && mac_tx_rst_n;
                s0_ready = orphan0;
                s1_ready = orphan1;
                if (|req) begin
                    state_d = ARB;
                end
            end

            ARB: begin
                if (!(|req)) begin
                    state_d = IDLE;
                end else if (winner == REQ_S1) begin
                    state_d = GRANT1;
                end else begin
                    state_d = GRANT0;
                end
            end

            GRANT0: begin
                m_valid  = s0_valid;
                m_start  = s0_start;
                m_last   = s0_last;
                m_data   = s0_data;
                m_keep   = s0_keep;
                m_user   = s0_user;
                s0_ready = m_ready;
                if (s0_valid && m_ready && s0_last) begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                end
            end

            GRANT1: begin
                m_valid  = s1_valid;
                m_start  = s1_start;
                m_last   = s1_last;
                m_data   = s1_data;
                m_keep   = s1_keep;
                m_user   = s1_user;
                s1_ready = m_ready;
                if (s1_valid && m_ready && s1_last) begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Per-requester frame counters wrap; the drop counter saturates
    always_ff @(posedge mac_tx_clk or negedge mac_tx_rst_n) begin
        if (!mac_tx_rst_n) begin
            frame_cnt0 <= '0;
            frame_cnt1 <= '0;
            drop_cnt   <= '0;
        end else begin
            if (frame_done && !grant_idx) begin
                frame_cnt0 <= frame_cnt0 + FRAME_CNT_W'(1);
            end
            if (frame_done && grant_idx) begin
                frame_cnt1 <= frame_cnt1 + FRAME_CNT_W'(1);
            end
            if (orphan0 || orphan1) begin
                drop_cnt <= drop_sat_add(drop_cnt, {1'b0, orphan0} + {1'b0, orphan1});
            end
        end
    end

endmodule

// File: tb/tb_link_tx_arbiter.sv
// Self-checking bench for link_tx_arbiter; frame-order reference model kept in queues.
`timescale 1ns/1ps
module tb_link_tx_arbiter;

    localparam int unsigned DW = 256;
    localparam int unsigned KW = 32;
    localparam int unsigned UW = 7;

    typedef struct packed {
        logic          start;
        logic          last;
        logic [UW-1:0] user;
        logic [KW-1:0] keep;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s0_valid, s0_start, s0_last, s0_ready;
    logic [DW-1:0] s0_data;
    logic [KW-1:0] s0_keep;
    logic [UW-1:0] s0_user;
    logic          s1_valid, s1_start, s1_last, s1_ready;
    logic [DW-1:0] s1_data;
    logic [KW-1:0] s1_keep;
    logic [UW-1:0] s1_user;
    logic          m_valid, m_start, m_last, m_ready;
    logic [DW-1:0] m_data;
    logic [KW-1:0] m_keep;
    logic [UW-1:0] m_user;
    logic [31:0]   frame_cnt0, frame_cnt1;
    logic [15:0]   drop_cnt;

    link_tx_arbiter #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) dut (
        .mac_tx_clk(clk), .mac_tx_rst_n(rst_n),
        .s0_valid(s0_valid), .s0_start(s0_start), .s0_last(s0_last), .s0_ready(s0_ready),
        .s0_data(s0_data), .s0_keep(s0_keep), .s0_user(s0_user),
        .s1_valid(s1_valid), .s1_start(s1_start), .s1_last(s1_last), .s1_ready(s1_ready),
        .s1_data(s1_data), .s1_keep(s1_keep), .s1_user(s1_user),
        .m_valid(m_valid), .m_start(m_start), .m_last(m_last), .m_ready(m_ready),
        .m_data(m_data), .m_keep(m_keep), .m_user(m_user),
        .frame_cnt0(frame_cnt0), .frame_cnt1(frame_cnt1), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int    errors = 0;
    int    checks = 0;
    beat_t q0[$], q1[$];
    beat_t e0[$], e1[$];
    beat_t exp_q[$], cap[$];
    int    cap_cyc[$];
    int    cyc = 0;
    int    mr_mode = 0;
    logic  hs0, hs1;
    logic  smp_s0_ready, smp_s1_ready, smp_m_valid, smp_m_ready;
    int    m_ptr, m_fcnt0, m_fcnt1, m_drop;

    function automatic beat_t mk_beat(input logic st, input logic ls);
        beat_t b;
        for (int k = 0; k < 8; k++) b.data[k*32 +: 32] = $urandom();
        b.keep  = $urandom();
        b.user  = UW'($urandom());
        b.start = st;
        b.last  = ls;
        return b;
    endfunction

    task automatic add_frame(input int src, input int len, input bit to_model);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b = mk_beat(i == 0, i == len - 1);
            if (src == 0) begin
                q0.push_back(b);
                if (to_model) e0.push_back(b);
            end else begin
                q1.push_back(b);
                if (to_model) e1.push_back(b);
            end
        end
    endtask

    task automatic drive();
        beat_t b;
        if (q0.size() > 0) begin
            b = q0[0];
            s0_valid = 1'b1; s0_start = b.start; s0_last = b.last;
            s0_data = b.data; s0_keep = b.keep; s0_user = b.user;
        end else begin
            s0_valid = 1'b0; s0_start = 1'b0; s0_last = 1'b0;
            s0_data = '0; s0_keep = '0; s0_user = '0;
        end
        if (q1.size() > 0) begin
            b = q1[0];
            s1_valid = 1'b1; s1_start = b.start; s1_last = b.last;
            s1_data = b.data; s1_keep = b.keep; s1_user = b.user;
        end else begin
            s1_valid = 1'b0; s1_start = 1'b0; s1_last = 1'b0;
            s1_data = '0; s1_keep = '0; s1_user = '0;
        end
        case (mr_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ($urandom_range(0, 3) != 0);
            default: m_ready = (cyc % 2 == 0);
        endcase
    endtask

    // One link cycle: drive, sample at negedge, retire accepted beats after posedge
    task automatic cycle();
        beat_t b;
        drive();
        @(negedge clk);
        smp_s0_ready = s0_ready;
        smp_s1_ready = s1_ready;
        smp_m_valid  = m_valid;
        smp_m_ready  = m_ready;
        hs0 = s0_valid && s0_ready;
        hs1 = s1_valid && s1_ready;
        if (m_valid && m_ready) begin
            b = {m_start, m_last, m_user, m_keep, m_data};
            cap.push_back(b);
            cap_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        if (hs0) q0.delete(0);
        if (hs1) q1.delete(0);
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q0.delete(); q1.delete(); e0.delete(); e1.delete();
        mr_mode = 0;
        drive();
        m_ptr = 0; m_fcnt0 = 0; m_fcnt1 = 0; m_drop = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        cap.delete(); cap_cyc.delete();
    endtask

    // Whole frames are granted in order: preferred source on a tie, pointer flips per frame
    task automatic build_exp();
        beat_t b;
        int    w;
        exp_q.delete();
        while (e0.size() > 0 || e1.size() > 0) begin
`ifdef ARB_STRICT_PRIO_EN
            w = (e0.size() > 0) ? 0 : 1;
`else
            if (e0.size() > 0 && e1.size() > 0) w = m_ptr;
            else w = (e0.size() > 0) ? 0 : 1;
`endif
            do begin
                if (w == 0) begin b = e0[0]; e0.delete(0); end
                else begin b = e1[0]; e1.delete(0); end
                exp_q.push_back(b);
            end while (!b.last);
            if (w == 0) m_fcnt0++; else m_fcnt1++;
            m_ptr = 1 - w;
        end
    endtask

    task automatic check_counters(input string name);
        checks++;
        if (frame_cnt0 !== 32'(m_fcnt0)) begin
            errors++;
            $display("FAIL %s frame_cnt0 got=%0d exp=%0d", name, frame_cnt0, m_fcnt0);
        end
        checks++;
        if (frame_cnt1 !== 32'(m_fcnt1)) begin
            errors++;
            $display("FAIL %s frame_cnt1 got=%0d exp=%0d", name, frame_cnt1, m_fcnt1);
        end
        checks++;
        if (drop_cnt !== 16'(m_drop)) begin
            errors++;
            $display("FAIL %s drop_cnt got=%0d exp=%0d", name, drop_cnt, m_drop);
        end
    endtask

    task automatic run_frames(input string name, input int budget);
        int n;
        build_exp();
        cap.delete(); cap_cyc.delete();
        cyc = 0;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || cap.size() < exp_q.size()) && n < budget) begin
            cycle();
            n++;
        end
        if (n >= budget) begin
            checks++; errors++;
            $display("FAIL %s timeout after %0d cycles", name, n);
        end
        repeat (2) cycle();
        checks++;
        if (cap.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s beat_count got=%0d exp=%0d", name, cap.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
            checks++;
            if (cap[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s beat[%0d] got=%h exp=%h", name, i, cap[i], exp_q[i]);
            end
        end
        check_counters(name);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s0_valid = 1'b1; s0_start = 1'b0; s0_last = 1'b0;
        s1_valid = 1'b1; s1_start = 1'b1; s1_last = 1'b1;
        m_ready = 1'b1;
        #2;
        checks++;
        if (m_valid !== 1'b0 || s0_ready !== 1'b0 || s1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got m_valid=%b s0_ready=%b s1_ready=%b exp=0", m_valid, s0_ready, s1_ready);
        end
        do_reset();
        check_counters("reset");
        cycle();
        checks++;
        if (smp_m_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle m_valid got=%b exp=0", smp_m_valid);
        end
    endtask

    task automatic test_basic();
        do_reset();
        add_frame(0, 3, 1'b1);
        run_frames("basic", 50);
        checks++;
        if (cap_cyc.size() < 3 || cap_cyc[0] != 2 || cap_cyc[2] != 4) begin
            errors++;
            $display("FAIL basic_latency got first=%0d exp first=2 last=4", (cap_cyc.size() > 0) ? cap_cyc[0] : -1);
        end
        // Pointer moved away from s0: on a tie s1 goes next
        add_frame(0, 1, 1'b1);
        add_frame(1, 1, 1'b1);
        run_frames("basic_ptr", 50);
    endtask

    task automatic test_alternate();
        do_reset();
        for (int f = 0; f < 2; f++) begin
            add_frame(0, 2, 1'b1);
            add_frame(1, 2, 1'b1);
        end
        run_frames("alternate", 100);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (cap_cyc.size() <= 2 * k || cap_cyc[2*k] != 2 + 4 * k) begin
                errors++;
                $display("FAIL alternate_gap frame %0d start got=%0d exp=%0d", k,
                         (cap_cyc.size() > 2 * k) ? cap_cyc[2*k] : -1, 2 + 4 * k);
            end
        end
    endtask

    task automatic test_backpressure();
        int   n;
        logic exp_rdy;
        do_reset();
        mr_mode = 2;
        add_frame(1, 4, 1'b1);
        build_exp();
        n = 0;
        while (q1.size() > 0 && n < 30) begin
            exp_rdy = (n >= 2) && (n % 2 == 0);
            cycle();
            checks++;
            if (smp_s1_ready !== exp_rdy || smp_s0_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_ready cyc %0d got s1=%b s0=%b exp s1=%b s0=0", n, smp_s1_ready, smp_s0_ready, exp_rdy);
            end
            n++;
        end
        mr_mode = 0;
        repeat (2) cycle();
        checks++;
        if (cap.size() != 4) begin
            errors++;
            $display("FAIL backpressure_count got=%0d exp=4", cap.size());
        end
        for (int i = 0; i < 4 && i < cap.size(); i++) begin
            checks++;
            if (cap[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL backpressure_beat[%0d] got=%h exp=%h", i, cap[i], exp_q[i]);
            end
        end
        check_counters("backpressure");
    endtask

    task automatic test_orphan();
        do_reset();
        for (int i = 0; i < 3; i++) q1.push_back(mk_beat(1'b0, 1'(i == 2)));
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (smp_s1_ready !== 1'b1 || smp_m_valid !== 1'b0) begin
                errors++;
                $display("FAIL orphan_cycle %0d got s1_ready=%b m_valid=%b exp 1/0", i, smp_s1_ready, smp_m_valid);
            end
        end
        m_drop = 3;
        check_counters("orphan3");
        for (int i = 0; i < 2; i++) begin
            q0.push_back(mk_beat(1'b0, 1'b0));
            q1.push_back(mk_beat(1'b0, 1'b0));
        end
        repeat (3) cycle();
        m_drop = 7;
        check_counters("orphan_both");
        checks++;
        if (cap.size() != 0 || q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL orphan_forwarded got cap=%0d left=%0d exp 0", cap.size(), q0.size() + q1.size());
        end
    endtask

    task automatic test_withdraw();
        do_reset();
        add_frame(0, 1, 1'b1);
        run_frames("withdraw_pre", 50);
        cap.delete();
        add_frame(1, 1, 1'b0);
        cycle();
        q1.delete();
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (smp_m_valid !== 1'b0 || smp_s1_ready !== 1'b0) begin
                errors++;
                $display("FAIL withdraw_idle %0d got m_valid=%b s1_ready=%b exp 0", i, smp_m_valid, smp_s1_ready);
            end
        end
        add_frame(0, 1, 1'b1);
        add_frame(1, 1, 1'b1);
        run_frames("withdraw_post", 50);
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        add_frame(1, 1, 1'b1);
        run_frames("single_beat", 50);
        cap.delete();
        add_frame(0, 5, 1'b0);
        n = 0;
        while (cap.size() < 2 && n < 20) begin
            cycle();
            n++;
        end
        checks++;
        if (cap.size() != 2) begin
            errors++;
            $display("FAIL reset_mid_pre got beats=%0d exp=2", cap.size());
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || m_start !== 1'b0 || m_last !== 1'b0 || m_data !== '0 ||
            m_keep !== '0 || m_user !== '0 || s0_ready !== 1'b0 || s1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs got m_valid=%b m_data_nz=%b s0_ready=%b exp 0", m_valid, |m_data, s0_ready);
        end
        m_ptr = 0; m_fcnt0 = 0; m_fcnt1 = 0; m_drop = 0;
        check_counters("reset_mid");
        q0.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        add_frame(0, 5, 1'b1);
        run_frames("reset_restart", 50);
        checks++;
        if (cap_cyc.size() < 1 || cap_cyc[0] != 2) begin
            errors++;
            $display("FAIL reset_restart_latency got=%0d exp=2", (cap_cyc.size() > 0) ? cap_cyc[0] : -1);
        end
    endtask

    task automatic test_random();
        do_reset();
        mr_mode = 1;
        for (int r = 0; r < 4; r++) begin
            int nf0, nf1;
            nf0 = $urandom_range(0, 3);
            nf1 = $urandom_range(1, 3);
            for (int f = 0; f < nf0; f++) add_frame(0, $urandom_range(1, 5), 1'b1);
            for (int f = 0; f < nf1; f++) add_frame(1, $urandom_range(1, 5), 1'b1);
            run_frames("random", 500);
        end
        mr_mode = 0;
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 32767; i++) begin
            q0.push_back(beat_t'(0));
            q1.push_back(beat_t'(0));
            cycle();
        end
        m_drop = 65534;
        check_counters("drop_near_sat");
        for (int i = 0; i < 2; i++) begin
            q0.push_back(beat_t'(0));
            q1.push_back(beat_t'(0));
            cycle();
            m_drop = 65535;
            check_counters("drop_sat");
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_alternate();
        test_backpressure();
        test_orphan();
        test_withdraw();
        test_reset_mid();
        test_random();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
